ub_port_arbiter: RTL and testbench

//  Shares the Unified Buffer's single byte write port and single byte read port between NUM_WR writers and NUM_RD readers.

---
 rtl/ub_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ub_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_port_arbiter.sv
// Arbitrates the Unified Buffer's single byte write port and single byte read port
// among several writers and readers, with burst locking and read-after-write stalls.
module ub_port_arbiter #(
    parameter  int SA_LENGTH  = 256,
    parameter  int ADDR_WIDTH = 10,
    parameter  int NO_BANKS   = 8,
    parameter  int NUM_WR     = 2,
    parameter  int NUM_RD     = 2,
    localparam int AW         = ADDR_WIDTH + $clog2(NO_BANKS) + $clog2(SA_LENGTH),
    localparam int IDW        = $clog2(NUM_RD)
) (
    input  logic                 CLK,
    input  logic                 ASYNC_RST,
    input  logic                 SYNC_RST,
    input  logic                 EN,
    input  logic [NUM_WR-1:0]    wr_req,
    input  logic [NUM_WR-1:0]    wr_lock,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*8-1:0]  wr_data,
    output logic [NUM_WR-1:0]    wr_gnt,
    input  logic [NUM_RD-1:0]    rd_req,
    input  logic [NUM_RD-1:0]    rd_lock,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_gnt,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 ub_en,
    output logic                 ub_sync_rst,
    output logic                 ub_wren,
    output logic [AW-1:0]        ub_wraddr,
    output logic [7:0]           ub_wrdata,
    output logic [AW-1:0]        ub_rdaddr,
    input  logic [7:0]           ub_rddata
);

    localparam int WPW = $clog2(NUM_WR);

    logic [WPW-1:0] wr_ptr;
    logic [WPW-1:0] wr_own;
    logic           wr_own_vld;
    logic [IDW-1:0] rd_ptr;
    logic [IDW-1:0] rd_own;
    logic           rd_own_vld;
    logic [AW-1:0]  last_rdaddr;

    logic           allow;
    logic           wr_found;
    logic [WPW-1:0] wr_idx;
    logic [WPW-1:0] wr_scan;
    logic           rd_found;
    logic [IDW-1:0] rd_idx;
    logic [IDW-1:0] rd_scan;
    logic           wr_any;
    logic           rd_win;
    logic           rd_any;
    logic           hazard;
    logic [AW-1:0]  rd_sel_addr;
    logic [WPW-1:0] wr_next;
    logic [IDW-1:0] rd_next;

    // Grants are suppressed while any reset is active or the block is disabled.
    assign allow = ASYNC_RST & EN & ~SYNC_RST;

    always_comb begin
        wr_found = 1'b0;
        wr_idx   = '0;
        wr_scan  = '0;
        if (wr_own_vld && wr_req[wr_own] && wr_lock[wr_own]) begin
            wr_found = 1'b1;
            wr_idx   = wr_own;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                wr_scan = WPW'((int'(wr_ptr) + i) % NUM_WR);
                if (!wr_found && wr_req[wr_scan]) begin
                    wr_found = 1'b1;
                    wr_idx   = wr_scan;
                end
            end
        end
    end

    always_comb begin
        rd_found = 1'b0;
        rd_idx   = '0;
        rd_scan  = '0;
        if (rd_own_vld && rd_req[rd_own] && rd_lock[rd_own]) begin
            rd_found = 1'b1;
            rd_idx   = rd_own;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_scan = IDW'((int'(rd_ptr) + i) % NUM_RD);
                if (!rd_found && rd_req[rd_scan]) begin
                    rd_found = 1'b1;
                    rd_idx   = rd_scan;
                end
            end
        end
    end

    assign wr_any      = allow & wr_found;
    assign rd_win      = allow & rd_found;
    assign rd_sel_addr = rd_addr[int'(rd_idx)*AW +: AW];
    assign ub_wraddr   = wr_any ? wr_addr[int'(wr_idx)*AW +: AW] : '0;
    assign ub_wrdata   = wr_any ? wr_data[int'(wr_idx)*8 +: 8] : '0;
    // A read of the byte being written this cycle is held off so it returns the new value.
    assign hazard      = wr_any & rd_win & (rd_sel_addr == ub_wraddr);
    assign rd_any      = rd_win & ~hazard;
    assign ub_rdaddr   = rd_any ? rd_sel_addr : last_rdaddr;

    assign wr_next = (wr_idx == WPW'(NUM_WR - 1)) ? '0 : wr_idx + 1'b1;
    assign rd_next = (rd_idx == IDW'(NUM_RD - 1)) ? '0 : rd_idx + 1'b1;

    always_comb begin
        wr_gnt = '0;
        if (wr_any) wr_gnt[wr_idx] = 1'b1;
    end

    always_comb begin
        rd_gnt = '0;
        if (rd_any) rd_gnt[rd_idx] = 1'b1;
    end

    assign ub_en       = EN;
    assign ub_sync_rst = SYNC_RST;
    assign ub_wren     = wr_any;
    assign rsp_data    = ub_rddata;

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            wr_ptr     <= '0;
            wr_own     <= '0;
            wr_own_vld <= 1'b0;
        end else if (EN) begin
            if (SYNC_RST) begin
                wr_ptr     <= '0;
                wr_own     <= '0;
                wr_own_vld <= 1'b0;
            end else if (wr_any) begin
                wr_ptr     <= wr_next;
                wr_own     <= wr_idx;
                wr_own_vld <= 1'b1;
            end else begin
                wr_own_vld <= 1'b0;
            end
        end
    end

    // A hazard-stalled reader keeps its pointer and lock so it simply retries.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            rd_ptr      <= '0;
            rd_own      <= '0;
            rd_own_vld  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            last_rdaddr <= '0;
        end else begin
            rsp_valid <= rd_any;
            if (EN) begin
                if (SYNC_RST) begin
                    rd_ptr      <= '0;
                    rd_own      <= '0;
                    rd_own_vld  <= 1'b0;
                    rsp_id      <= '0;
                    last_rdaddr <= '0;
                end else if (rd_any) begin
                    rd_ptr      <= rd_next;
                    rd_own      <= rd_idx;
                    rd_own_vld  <= 1'b1;
                    rsp_id      <= rd_idx;
                    last_rdaddr <= rd_sel_addr;
                end else if (!hazard) begin
                    rd_own_vld  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Bench for ub_port_arbiter: a behavioural buffer supplies read data, and expected
// read responses are queued when grants are expected and matched as they arrive.
module tb_ub_port_arbiter;

    localparam int AW = 21;

    logic            CLK;
    logic            ASYNC_RST;
    logic            SYNC_RST;
    logic            EN;
    logic [1:0]      wr_req;
    logic [1:0]      wr_lock;
    logic [2*AW-1:0] wr_addr;
    logic [15:0]     wr_data;
    logic [1:0]      wr_gnt;
    logic [1:0]      rd_req;
    logic [1:0]      rd_lock;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]      rd_gnt;
    logic            rsp_valid;
    logic [0:0]      rsp_id;
    logic [7:0]      rsp_data;
    logic            ub_en;
    logic            ub_sync_rst;
    logic            ub_wren;
    logic [AW-1:0]   ub_wraddr;
    logic [7:0]      ub_wrdata;
    logic [AW-1:0]   ub_rdaddr;
    logic [7:0]      ub_rddata;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] mem [int];
    int         errors = 0;
    int         checks = 0;

    ub_port_arbiter dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_lock(rd_lock), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .ub_en(ub_en), .ub_sync_rst(ub_sync_rst), .ub_wren(ub_wren),
        .ub_wraddr(ub_wraddr), .ub_wrdata(ub_wrdata), .ub_rdaddr(ub_rdaddr),
        .ub_rddata(ub_rddata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Buffer with a one-cycle registered read; reads see the contents before this edge's write.
    always @(posedge CLK) begin : ub_model
        logic [7:0] rd_byte;
        rd_byte = mem.exists(int'(ub_rdaddr)) ? mem[int'(ub_rdaddr)] : 8'h00;
        if (ub_wren) mem[int'(ub_wraddr)] = ub_wrdata;
        ub_rddata <= rd_byte;
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [7:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*8 +: 8]   = d;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic monitor_rsp();
        rsp_t e;
        forever begin
            @(negedge CLK);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected got id=%0d data=%h want no response", rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data) begin
                        errors++;
                        $display("[TB] FAIL rsp_match got id=%0d data=%h want id=%0d data=%h",
                                 rsp_id, rsp_data, e.id, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #1 ASYNC_RST = 1'b0;
        set_wr(0, 21'h10, 8'h11);
        set_wr(1, 21'h11, 8'h22);
        set_rd(0, 21'h20);
        set_rd(1, 21'h21);
        wr_req = 2'b11;
        rd_req = 2'b11;
        repeat (2) next_cycle();
        settle();
        checks++; if (wr_gnt !== 2'b00) begin errors++; $display("[TB] FAIL rst_wr_gnt got=%b want=00", wr_gnt); end
        checks++; if (rd_gnt !== 2'b00) begin errors++; $display("[TB] FAIL rst_rd_gnt got=%b want=00", rd_gnt); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (ub_wren !== 1'b0) begin errors++; $display("[TB] FAIL rst_ub_wren got=%b want=0", ub_wren); end
        checks++; if (ub_rdaddr !== 21'h0) begin errors++; $display("[TB] FAIL rst_ub_rdaddr got=%h want=0", ub_rdaddr); end
        next_cycle();
        ASYNC_RST = 1'b1;
        settle();
        checks++; if (wr_gnt !== 2'b01) begin errors++; $display("[TB] FAIL rel_wr_gnt got=%b want=01", wr_gnt); end
        checks++; if (rd_gnt !== 2'b01) begin errors++; $display("[TB] FAIL rel_rd_gnt got=%b want=01", rd_gnt); end
        checks++; if (ub_wraddr !== 21'h10 || ub_wrdata !== 8'h11) begin
            errors++; $display("[TB] FAIL rel_wr_port got=%h/%h want=10/11", ub_wraddr, ub_wrdata);
        end
        checks++; if (ub_rdaddr !== 21'h20) begin errors++; $display("[TB] FAIL rel_ub_rdaddr got=%h want=20", ub_rdaddr); end
        exp_q.push_back({1'b0, 8'h00});
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        next_cycle();
        wr_req = 2'b10;
        rd_req = 2'b00;
        settle();
        checks++; if (wr_gnt !== 2'b10) begin errors++; $display("[TB] FAIL rr_setup got=%b want=10", wr_gnt); end
        set_wr(0, 21'h30, 8'h33);
        set_wr(1, 21'h31, 8'h44);
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            wr_req = 2'b11;
            settle();
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (c % 2 == 0) ? 8'h33 : 8'h44;
            checks++; if (wr_gnt !== exp_g || ub_wrdata !== exp_d) begin
                errors++; $display("[TB] FAIL rr_cycle%0d got=%b/%h want=%b/%h", c, wr_gnt, ub_wrdata, exp_g, exp_d);
            end
        end
    endtask

    task automatic test_write_read();
        next_cycle();
        wr_req = 2'b01;
        set_wr(0, 21'h00105, 8'hA5);
        settle();
        checks++; if (wr_gnt !== 2'b01 || ub_wraddr !== 21'h105 || ub_wrdata !== 8'hA5) begin
            errors++; $display("[TB] FAIL wr_a5 got=%b/%h/%h want=01/105/a5", wr_gnt, ub_wraddr, ub_wrdata);
        end
        next_cycle();
        wr_req = 2'b00;
        rd_req = 2'b10;
        set_rd(1, 21'h00105);
        settle();
        checks++; if (rd_gnt !== 2'b10 || ub_rdaddr !== 21'h105) begin
            errors++; $display("[TB] FAIL rd_a5 got=%b/%h want=10/105", rd_gnt, ub_rdaddr);
        end
        exp_q.push_back({1'b1, 8'hA5});
        next_cycle();
        rd_req = 2'b00;
        settle();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rsp_a5_valid got=%b want=1", rsp_valid); end
        checks++; if (ub_rdaddr !== 21'h105) begin errors++; $display("[TB] FAIL rdaddr_hold got=%h want=105", ub_rdaddr); end
        checks++; if (ub_wren !== 1'b0 || ub_wraddr !== 21'h0) begin
            errors++; $display("[TB] FAIL idle_wr got=%b/%h want=0/0", ub_wren, ub_wraddr);
        end
        next_cycle();
        settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_rsp got=%b want=0", rsp_valid); end
    endtask

    task automatic test_raw_hazard();
        next_cycle();
        wr_req = 2'b01;
        set_wr(0, 21'h3, 8'h5A);
        rd_req = 2'b01;
        set_rd(0, 21'h3);
        settle();
        checks++; if (wr_gnt !== 2'b01 || rd_gnt !== 2'b00) begin
            errors++; $display("[TB] FAIL raw_stall got=%b/%b want=01/00", wr_gnt, rd_gnt);
        end
        next_cycle();
        wr_req = 2'b00;
        settle();
        checks++; if (rd_gnt !== 2'b01) begin errors++; $display("[TB] FAIL raw_retry got=%b want=01", rd_gnt); end
        exp_q.push_back({1'b0, 8'h5A});
        next_cycle();
        wr_req = 2'b10;
        set_wr(1, 21'h7, 8'h77);
        rd_req = 2'b10;
        set_rd(1, 21'h105);
        settle();
        checks++; if (wr_gnt !== 2'b10 || rd_gnt !== 2'b10) begin
            errors++; $display("[TB] FAIL diff_addr got=%b/%b want=10/10", wr_gnt, rd_gnt);
        end
        exp_q.push_back({1'b1, 8'hA5});
        next_cycle();
        wr_req = 2'b00;
        rd_req = 2'b00;
        settle();
    endtask

    task automatic test_lock();
        next_cycle();
        wr_req  = 2'b01;
        wr_lock = 2'b00;
        set_wr(0, 21'h60, 8'h01);
        set_wr(1, 21'h61, 8'h02);
        settle();
        checks++; if (wr_gnt !== 2'b01) begin errors++; $display("[TB] FAIL lock_setup got=%b want=01", wr_gnt); end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            wr_req  = 2'b11;
            wr_lock = 2'b10;
            settle();
            checks++; if (wr_gnt !== 2'b10) begin errors++; $display("[TB] FAIL lock_hold%0d got=%b want=10", c, wr_gnt); end
        end
        next_cycle();
        wr_req = 2'b01;
        settle();
        checks++; if (wr_gnt !== 2'b01) begin errors++; $display("[TB] FAIL lock_req_drop got=%b want=01", wr_gnt); end
        next_cycle();
        wr_req = 2'b11;
        settle();
        checks++; if (wr_gnt !== 2'b10) begin errors++; $display("[TB] FAIL lock_again got=%b want=10", wr_gnt); end
        next_cycle();
        wr_lock = 2'b00;
        settle();
        checks++; if (wr_gnt !== 2'b01) begin errors++; $display("[TB] FAIL lock_release got=%b want=01", wr_gnt); end
        next_cycle();
        wr_req = 2'b00;
        settle();
    endtask

    task automatic test_sync_reset();
        logic [1:0] exp_g;
        set_rd(0, 21'h10);
        set_rd(1, 21'h105);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            rd_req = 2'b11;
            settle();
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (rd_gnt !== exp_g) begin errors++; $display("[TB] FAIL alt_rd%0d got=%b want=%b", c, rd_gnt, exp_g); end
            if (c % 2 == 0) exp_q.push_back({1'b0, 8'h11});
            else            exp_q.push_back({1'b1, 8'hA5});
        end
        next_cycle();
        SYNC_RST = 1'b1;
        wr_req   = 2'b11;
        set_wr(0, 21'h40, 8'h99);
        set_wr(1, 21'h41, 8'h98);
        settle();
        checks++; if (rd_gnt !== 2'b00 || wr_gnt !== 2'b00 || ub_wren !== 1'b0) begin
            errors++; $display("[TB] FAIL srst_gnt got=%b/%b/%b want=00/00/0", rd_gnt, wr_gnt, ub_wren);
        end
        checks++; if (ub_sync_rst !== 1'b1) begin errors++; $display("[TB] FAIL srst_pass got=%b want=1", ub_sync_rst); end
        next_cycle();
        SYNC_RST = 1'b0;
        settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL srst_rsp got=%b want=0", rsp_valid); end
        checks++; if (rd_gnt !== 2'b01 || wr_gnt !== 2'b01) begin
            errors++; $display("[TB] FAIL srst_ptr got=%b/%b want=01/01", rd_gnt, wr_gnt);
        end
        exp_q.push_back({1'b0, 8'h11});
        next_cycle();
        rd_req = 2'b00;
        wr_req = 2'b00;
        settle();
    endtask

    task automatic test_enable();
        next_cycle();
        EN     = 1'b0;
        wr_req = 2'b11;
        rd_req = 2'b11;
        set_wr(0, 21'h50, 8'h55);
        set_wr(1, 21'h51, 8'h66);
        settle();
        checks++; if (wr_gnt !== 2'b00 || rd_gnt !== 2'b00 || ub_en !== 1'b0) begin
            errors++; $display("[TB] FAIL en_off got=%b/%b/%b want=00/00/0", wr_gnt, rd_gnt, ub_en);
        end
        next_cycle();
        EN = 1'b1;
        settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL en_rsp got=%b want=0", rsp_valid); end
        checks++; if (wr_gnt !== 2'b10 || rd_gnt !== 2'b10) begin
            errors++; $display("[TB] FAIL en_hold_ptr got=%b/%b want=10/10", wr_gnt, rd_gnt);
        end
        exp_q.push_back({1'b1, 8'hA5});
        next_cycle();
        wr_req = 2'b00;
        rd_req = 2'b00;
        settle();
        next_cycle();
        settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL en_drain got=%b want=0", rsp_valid); end
    endtask

    initial begin
        ASYNC_RST = 1'b1;
        SYNC_RST  = 1'b0;
        EN        = 1'b1;
        wr_req    = '0;
        wr_lock   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_req    = '0;
        rd_lock   = '0;
        rd_addr   = '0;
        fork
            monitor_rsp();
        join_none
        test_reset();
        test_round_robin();
        test_write_read();
        test_raw_hazard();
        test_lock();
        test_sync_reset();
        test_enable();
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rsp_missing got=%0d outstanding want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
